accumulator_channel_array: RTL

Parametrised successor to the fixed two-pair accumulator path. It accepts NUM_CH one-bit comparator/sampler streams on the accumulator clock and decimates each enabled channel over a programmable window. Each channel runs in unsigned (count-ones) or signed (±1) mode with saturation. Completed windows are serialised onto one output pin with a start marker, a programmable bit rate and frame-drop accounting. It sits between the flopped sampler outputs and the serial output pads, and is configured from the control registers.

---
 rtl/accumulator_channel_array.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/accumulator_channel_array.sv
// Multi-channel windowed decimating accumulator with saturation, feeding one
// framed serial output (start marker, programmable bit period, drop counter).
module accumulator_channel_array #(
    parameter int NUM_CH    = 4,
    parameter int ACC_WIDTH = 16,
    parameter int DSR_WIDTH = 16,
    parameter int DIV_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    dataIn,
    input  logic [NUM_CH-1:0]    chanEnable,
    input  logic                 signedMode,
    input  logic [DSR_WIDTH-1:0] DSRatio,
    input  logic [DIV_WIDTH-1:0] serialDiv,
    output logic                 serialOut,
    output logic                 serialStart,
    output logic                 serialBusy,
    output logic [NUM_CH-1:0]    overflowFlags,
    output logic [7:0]           dropCount
);

    localparam int FRAME_BITS = NUM_CH * ACC_WIDTH;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

    localparam logic [ACC_WIDTH-1:0] ACC_ONE = ACC_WIDTH'(1);
    localparam logic [ACC_WIDTH-1:0] U_MAX   = '1;
    localparam logic [ACC_WIDTH-1:0] S_MAX   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] S_MIN   = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [DSR_WIDTH-1:0] DSR_ONE = DSR_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
    localparam logic [BIT_CNT_W-1:0] BIT_ONE  = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    logic [ACC_WIDTH-1:0]  acc_q [NUM_CH];
    logic [ACC_WIDTH-1:0]  accSum [NUM_CH];
    logic [NUM_CH-1:0]     satNow;
    logic [NUM_CH-1:0]     satFlag_q;
    logic [NUM_CH-1:0]     overflow_q;
    logic [DSR_WIDTH-1:0]  cnt_q;
    logic [FRAME_BITS-1:0] snapshot_q;
    logic                  snapshotValid_q;
    logic                  windowActive;
    logic                  windowEnd;

    state_t                state_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DIV_WIDTH-1:0]  divCnt_q;
    logic [BIT_CNT_W-1:0]  bitCnt_q;
    logic                  serialOut_q;
    logic                  serialStart_q;
    logic                  serialBusy_q;
    logic [7:0]            dropCount_q;
    logic                  bitDone;
    logic                  frameDone;
    logic                  loadFrame;
    logic                  dropFrame;

    assign windowActive = (DSRatio != '0);
    // Using >= lets a window end at once when DSRatio shrinks below the count.
    assign windowEnd    = windowActive && (cnt_q >= (DSRatio - DSR_ONE));

    // Accumulator value including this cycle's sample, clamped at the mode's range.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            accSum[ch] = acc_q[ch];
            satNow[ch] = 1'b0;
            if (chanEnable[ch]) begin
                if (dataIn[ch]) begin
                    if (acc_q[ch] == (signedMode ? S_MAX : U_MAX)) begin
                        satNow[ch] = 1'b1;
                    end else begin
                        accSum[ch] = acc_q[ch] + ACC_ONE;
                    end
                end else if (signedMode) begin
                    if (acc_q[ch] == S_MIN) begin
                        satNow[ch] = 1'b1;
                    end else begin
                        accSum[ch] = acc_q[ch] - ACC_ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q           <= '0;
            satFlag_q       <= '0;
            overflow_q      <= '0;
            snapshot_q      <= '0;
            snapshotValid_q <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                acc_q[ch] <= '0;
            end
        end else begin
            snapshotValid_q <= windowEnd;
            if (!windowActive) begin
                cnt_q     <= '0;
                satFlag_q <= '0;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    acc_q[ch] <= '0;
                end
            end else if (windowEnd) begin
                cnt_q      <= '0;
                satFlag_q  <= '0;
                overflow_q <= (satFlag_q | satNow) & chanEnable;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    acc_q[ch] <= '0;
                    snapshot_q[ch*ACC_WIDTH +: ACC_WIDTH] <= chanEnable[ch] ? accSum[ch] : '0;
                end
            end else begin
                cnt_q     <= cnt_q + DSR_ONE;
                satFlag_q <= satFlag_q | satNow;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    acc_q[ch] <= accSum[ch];
                end
            end
        end
    end

    assign bitDone   = (divCnt_q == div_q);
    assign frameDone = (state_q == SHIFT) && bitDone && (bitCnt_q == LAST_BIT);
    // The last cycle of the last bit can accept a new frame without a gap.
    assign loadFrame = snapshotValid_q && ((state_q == IDLE) || frameDone);
    assign dropFrame = snapshotValid_q && (state_q == SHIFT) && !frameDone;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            div_q         <= '0;
            divCnt_q      <= '0;
            bitCnt_q      <= '0;
            serialOut_q   <= 1'b0;
            serialStart_q <= 1'b0;
            serialBusy_q  <= 1'b0;
            dropCount_q   <= '0;
        end else begin
            if (dropFrame && (dropCount_q != 8'hFF)) begin
                dropCount_q <= dropCount_q + 8'd1;
            end
            if (loadFrame) begin
                state_q       <= SHIFT;
                shift_q       <= snapshot_q;
                div_q         <= serialDiv;
                divCnt_q      <= '0;
                bitCnt_q      <= '0;
                serialOut_q   <= snapshot_q[FRAME_BITS-1];
                serialStart_q <= 1'b1;
                serialBusy_q  <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        serialOut_q   <= 1'b0;
                        serialStart_q <= 1'b0;
                        serialBusy_q  <= 1'b0;
                    end
                    SHIFT: begin
                        if (frameDone) begin
                            state_q       <= IDLE;
                            serialOut_q   <= 1'b0;
                            serialStart_q <= 1'b0;
                            serialBusy_q  <= 1'b0;
                        end else if (bitDone) begin
                            divCnt_q      <= '0;
                            bitCnt_q      <= bitCnt_q + BIT_ONE;
                            shift_q       <= shift_q << 1;
                            serialOut_q   <= shift_q[FRAME_BITS-2];
                            serialStart_q <= 1'b0;
                        end else begin
                            divCnt_q <= divCnt_q + DIV_ONE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign serialOut     = serialOut_q;
    assign serialStart   = serialStart_q;
    assign serialBusy    = serialBusy_q;
    assign overflowFlags = overflow_q;
    assign dropCount     = dropCount_q;

endmodule
